mem_exception_unit: RTL
=======================

Name: mem_exception_unit

Overview:
MEM-stage exception arbiter that sits directly upstream of the CP0 register file. It merges the exception flags carried down the pipeline with the pending hardware-interrupt condition, and drives the final exception type, delay-slot flag and instruction address into CP0 in the same cycle. On the following cycle it issues a one-cycle pipeline flush and redirect PC to the pipeline control block.

Parameters:
EXC_VECTOR, 32'h00000020, redirect target for every exception except ERET
CNT_W, 16, width of the saturating taken-exception counter

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low (rst==0 resets on the rising clk edge)
mem_valid_i  in  1  MEM holds a real instruction (0 = bubble)
excepttype_i  in  32  flags from ID/EX: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret
inst_addr_i  in  32  PC of the MEM instruction
is_in_delayslot_i  in  1  MEM instruction is in a delay slot
cp0_status_i  in  32  CP0 Status, committed value
cp0_cause_i  in  32  CP0 Cause, committed value
cp0_epc_i  in  32  CP0 EPC, committed value
wb_cp0_we_i  in  1  WB-stage CP0 write enable
wb_cp0_waddr_i  in  5  WB-stage CP0 write address
wb_cp0_wdata_i  in  32  WB-stage CP0 write data
exception_type_o  out  32  final type to CP0: 1 interrupt, 8 syscall, 0xa invalid, 0xd trap, 0xc overflow, 0xe eret, 0 none
is_in_delayslot_o  out  1  to CP0, pass-through
inst_addr_o  out  32  to CP0, pass-through
flush_o  out  1  one-cycle flush pulse to pipeline control
new_pc_o  out  32  redirect PC; valid only while flush_o=1
exc_count_o  out  CNT_W  count of taken exceptions, saturating

Behaviour:
- Reset (rst=0 at a clk edge):
  - flush_o=0, new_pc_o=0, exc_count_o=0.
  - State=IDLE, int_pending=0.
  - Combinational outputs are forced to 0 while rst=0.
- CP0 forwarding, applied before any use of the CP0 inputs:
  - If wb_cp0_we_i=1 and waddr=12: status = wdata.
  - If wb_cp0_we_i=1 and waddr=14: epc = wdata.
  - If wb_cp0_we_i=1 and waddr=13: cause = committed cause with bits 9:8, 22 and 23 replaced from wdata.
  - Otherwise the committed values are used.
- Interrupt condition: int_cond = |(cause[15:8] & status[15:8]) && status[0]==1 && status[1]==0.
- int_pending (registered):
  - Set when int_cond=1 and mem_valid_i=0 in IDLE.
  - Cleared when an exception is taken, or when int_cond drops.
- Detection is combinational and happens only in IDLE with mem_valid_i=1. Priority, highest first:
  1. interrupt (int_cond or int_pending)
  2. syscall
  3. invalid instruction
  4. trap
  5. overflow
  6. eret
- exception_type_o carries the winning code in the same cycle (zero latency to CP0).
- exception_type_o is 0 when:
  - the state is FLUSH;
  - mem_valid_i=0;
  - no flag is set.
- is_in_delayslot_o and inst_addr_o are pass-through. They are zero when mem_valid_i=0.
- FSM:
  - IDLE → FLUSH on any nonzero exception_type_o. The redirect PC is registered at that edge:
    - eret: forwarded epc;
    - any other exception: EXC_VECTOR.
  - FLUSH: flush_o=1 for exactly one cycle, new_pc_o holds the registered target. All detection is suppressed. Unconditionally returns to IDLE.
  - Back-to-back exceptions are therefore at least 2 cycles apart. Any exception presented during FLUSH is dropped, since that instruction is flushed.
  - new_pc_o returns to 0 in IDLE.
- exc_count_o increments by 1 on each IDLE→FLUSH transition. It saturates at all-ones, with no wrap.
- An interrupt always wins over a simultaneous synchronous exception or eret on the same instruction. EPC handling is owned by CP0.
- Reset asserted while in FLUSH: flush_o=0 at the next edge and the state returns to IDLE.
- ERET redirect uses the forwarded EPC, so a WB-stage mtc0 EPC in the same cycle takes effect.

Test Plan:
- Reset and idle: rst=0 for 2 cycles, then rst=1 with no flags → flush_o=0, new_pc_o=0, exc_count_o=0, exception_type_o=0.
- Syscall: mem_valid_i=1, excepttype_i=0x100, inst_addr_i=0x40 → exception_type_o=8 in the same cycle; next cycle flush_o=1, new_pc_o=0x20; the cycle after, flush_o=0; exc_count_o=1.
- Interrupt priority: status=0x0000FF01, cause[10]=1, excepttype_i=0x900 → exception_type_o=1, new_pc_o=0x20.
- Pending interrupt over a bubble: int_cond=1 with mem_valid_i=0 for 3 cycles → no flush; then mem_valid_i=1 at PC 0x80 → exception_type_o=1, inst_addr_o=0x80, flush follows.
- ERET with forwarding: excepttype_i=0x1000, cp0_epc_i=0x100, WB writes EPC (addr 14) = 0x200 in the same cycle → exception_type_o=0xe, next-cycle new_pc_o=0x200.
- Suppression and saturation: overflow presented in the FLUSH cycle → exception_type_o=0 and no second flush; with CNT_W=2, 5 exceptions → exc_count_o=3.

Source files
------------

// File: rtl/mem_exception_unit.sv
// -----------------------------------------------------------------------------
// mem_exception_unit
//
// MEM-stage exception arbiter placed directly upstream of the CP0 register file.
// It merges the exception flags carried down the pipeline with the pending
// hardware-interrupt condition. In the same cycle it drives the winning
// exception code, the delay-slot flag and the instruction address into CP0.
// On the following cycle it issues a one-cycle flush and a redirect PC to
// pipeline control.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   mem_valid_i          MEM holds a real instruction (0 = bubble)
//   excepttype_i         pipeline flags: [8] syscall, [9] invalid, [10] trap,
//                        [11] overflow, [12] eret
//   inst_addr_i          PC of the MEM instruction
//   is_in_delayslot_i    MEM instruction sits in a delay slot
//   cp0_status_i/cause_i/epc_i   committed CP0 values
//   wb_cp0_we_i/waddr_i/wdata_i  WB-stage CP0 write, forwarded here
//   exception_type_o     final code to CP0 (1 int, 8 sys, a inv, d trap,
//                        c ovf, e eret, 0 none)
//   is_in_delayslot_o    delay-slot flag to CP0
//   inst_addr_o          instruction address to CP0
//   flush_o              one-cycle flush pulse
//   new_pc_o             redirect target, meaningful only while flush_o=1
//   exc_count_o          saturating count of taken exceptions
// -----------------------------------------------------------------------------
module mem_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_i,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             is_in_delayslot_i,
    input  logic [31:0]      cp0_status_i,
    input  logic [31:0]      cp0_cause_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             wb_cp0_we_i,
    input  logic [4:0]       wb_cp0_waddr_i,
    input  logic [31:0]      wb_cp0_wdata_i,
    output logic [31:0]      exception_type_o,
    output logic             is_in_delayslot_o,
    output logic [31:0]      inst_addr_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic [CNT_W-1:0] exc_count_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    localparam logic [31:0] CODE_INT  = 32'h0000_0001;
    localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
    localparam logic [31:0] CODE_INV  = 32'h0000_000a;
    localparam logic [31:0] CODE_TRAP = 32'h0000_000d;
    localparam logic [31:0] CODE_OVF  = 32'h0000_000c;
    localparam logic [31:0] CODE_ERET = 32'h0000_000e;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_int_pending;
    logic [31:0]       r_new_pc;
    logic [CNT_W-1:0]  r_cnt;

    logic [31:0]       w_status;
    logic [31:0]       w_cause;
    logic [31:0]       w_epc;
    logic              w_int_cond;
    logic              w_detect;
    logic [31:0]       w_exc_type;
    logic              w_take;
    logic [31:0]       w_target;
    logic              w_unused_bits;

    // WB-stage mtc0 forwarding; only the software-interrupt bits and IV/WP
    // of Cause are writable, everything else comes from the committed value.
    always_comb begin
        w_status = cp0_status_i;
        w_cause  = cp0_cause_i;
        w_epc    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                ADDR_STATUS: w_status = wb_cp0_wdata_i;
                ADDR_EPC:    w_epc    = wb_cp0_wdata_i;
                ADDR_CAUSE:  w_cause  = {cp0_cause_i[31:24], wb_cp0_wdata_i[23:22],
                                         cp0_cause_i[21:10], wb_cp0_wdata_i[9:8],
                                         cp0_cause_i[7:0]};
                default: ;
            endcase
        end
    end

    // Interrupts need IE=1 and EXL=0.
    assign w_int_cond = (|(w_cause[15:8] & w_status[15:8])) && w_status[0] && !w_status[1];

    // Nothing is detected under reset, during the flush cycle, or on a bubble.
    assign w_detect = rst && (r_state == ST_IDLE) && mem_valid_i;

    always_comb begin
        w_exc_type = 32'h0;
        if (w_detect) begin
            if (w_int_cond || r_int_pending) w_exc_type = CODE_INT;
            else if (excepttype_i[8])        w_exc_type = CODE_SYS;
            else if (excepttype_i[9])        w_exc_type = CODE_INV;
            else if (excepttype_i[10])       w_exc_type = CODE_TRAP;
            else if (excepttype_i[11])       w_exc_type = CODE_OVF;
            else if (excepttype_i[12])       w_exc_type = CODE_ERET;
        end
    end

    assign w_take   = (w_exc_type != 32'h0);
    assign w_target = (w_exc_type == CODE_ERET) ? w_epc : EXC_VECTOR;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_take) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_int_pending <= 1'b0;
            r_new_pc      <= 32'h0;
            r_cnt         <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_new_pc <= w_take ? w_target : 32'h0;
            // Remember an interrupt that arrived while MEM held a bubble, so
            // it is taken on the next real instruction.
            if (w_take || !w_int_cond)
                r_int_pending <= 1'b0;
            else if ((r_state == ST_IDLE) && !mem_valid_i)
                r_int_pending <= 1'b1;
            if (w_take && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign exception_type_o  = w_exc_type;
    assign is_in_delayslot_o = (rst && mem_valid_i) ? is_in_delayslot_i : 1'b0;
    assign inst_addr_o       = (rst && mem_valid_i) ? inst_addr_i : 32'h0;
    assign flush_o           = (r_state == ST_FLUSH);
    assign new_pc_o          = r_new_pc;
    assign exc_count_o       = r_cnt;

    assign w_unused_bits = ^{excepttype_i[31:13], excepttype_i[7:0],
                             w_status[31:16], w_status[7:2],
                             w_cause[31:16], w_cause[7:0]};

endmodule
